instr_pair_ctrl: RTL and testbench
==================================

INSTR_PAIR_CTRL -- requirements
Module: instr_pair_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 15, max idle cycles in PAIR_WAIT before abort; range 1..255; used only when PAIR_TIMEOUT_EN is defined.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 instr_valid_i  input  1  fetch presents a halfword on instruction_i.
REQ-005 instruction_i  input  16  fetched Thumb halfword.
REQ-006 instr_ready_o  output  1  controller accepts the halfword this cycle.
REQ-007 stall_i  input  1  decode/imm_gen stage cannot take a new output this cycle.
REQ-008 flush_i  input  1  branch redirect; discard all held state.
REQ-009 out_valid_o  output  1  complete instruction presented to decode.
REQ-010 first_hw_o  output  16  first halfword; the only halfword for 16-bit instructions.
REQ-011 second_hw_o  output  16  second halfword of a 32-bit instruction; 16'h0000 for 16-bit.
REQ-012 is_32bit_o  output  1  output instruction is 32-bit.
REQ-013 pair_pending_o  output  1  first half of a 32-bit instruction held, second not yet received.
REQ-014 pair_fault_o  output  1  one-cycle pulse on timeout abort (tied 0 without PAIR_TIMEOUT_EN).

Function
REQ-015 Accept = instr_valid_i && instr_ready_o && !flush_i; nothing else changes state except rst_i, flush_i, output drain, and timeout.
REQ-016 instr_ready_o = !out_valid_o || !stall_i; combinational, no dependency on instr_valid_i.
REQ-017 Halfword is a 32-bit prefix iff instruction_i[15:11] is 5'b11101, 5'b11110 or 5'b11111.
REQ-018 FSM states: IDLE, PAIR_WAIT; output register (out_valid_o, first_hw_o, second_hw_o, is_32bit_o) is separate from the FSM.
REQ-019 IDLE, accepted non-prefix: load output register (first_hw_o=halfword, second_hw_o=0, is_32bit_o=0); out_valid_o=1 next cycle; stay IDLE.
REQ-020 IDLE, accepted prefix: latch halfword in prefix register; go to PAIR_WAIT; output register unchanged except drain per REQ-022.
REQ-021 PAIR_WAIT, accepted halfword (any encoding, never re-decoded as prefix): load output register with {prefix, halfword}, is_32bit_o=1; go to IDLE.
REQ-022 Drain: out_valid_o && !stall_i clears out_valid_o next cycle unless a load occurs in the same cycle (load wins; back-to-back throughput 1 per cycle).
REQ-023 out_valid_o && stall_i: output register and out_valid_o hold unchanged; instr_ready_o=0.
REQ-024 Latency: 16-bit accepted cycle N -> out_valid_o cycle N+1; 32-bit second half accepted cycle M -> out_valid_o cycle M+1.
REQ-025 pair_pending_o = (state == PAIR_WAIT).
REQ-026 flush_i: next cycle state=IDLE, out_valid_o=0, prefix discarded; halfword presented in the flush cycle discarded; flush dominates simultaneous accept, drain and stall.
REQ-027 first_hw_o/second_hw_o/is_32bit_o value when out_valid_o=0: holds last loaded value; decode ignores them.

Reset
REQ-028 rst_i (sync) sets state=IDLE, out_valid_o=0, first_hw_o=0, second_hw_o=0, is_32bit_o=0, pair_fault_o=0, timeout counter=0, prefix register=0.
REQ-029 rst_i dominates flush_i and all accepts; mid-pair reset discards the prefix with no fault pulse.

Configuration
REQ-030 Macro INSTR_PAIR_TIMEOUT_EN: when defined, 8-bit counter clears on PAIR_WAIT entry, increments each PAIR_WAIT cycle without accept; reaching TIMEOUT_CYCLES returns to IDLE, discards prefix, pulses pair_fault_o for one cycle.
REQ-031 Without INSTR_PAIR_TIMEOUT_EN: no counter exists, PAIR_WAIT persists indefinitely, pair_fault_o tied 0.

Verification
REQ-032 Reset, then 16'h2005 accepted cycle 1, stall_i=0 -> cycle 2 out_valid_o=1, first_hw_o=16'h2005, is_32bit_o=0, second_hw_o=0; cycle 3 out_valid_o=0.
REQ-033 16'hF000 then 16'hF800 on consecutive cycles -> pair_pending_o=1 one cycle; then out_valid_o=1, first_hw_o=16'hF000, second_hw_o=16'hF800, is_32bit_o=1.
REQ-034 out_valid_o=1 with stall_i=1 for 3 cycles, instr_valid_i=1 -> instr_ready_o=0, outputs frozen 3 cycles; stall release -> next halfword loaded same cycle, out_valid_o stays 1.
REQ-035 16'hF000 accepted, then flush_i=1 with 16'h2005 presented -> next cycle pair_pending_o=0, out_valid_o=0; following 16'h2105 emerges as 16-bit.
REQ-036 INSTR_PAIR_TIMEOUT_EN, TIMEOUT_CYCLES=4: 16'hF000 accepted, instr_valid_i=0 thereafter -> pair_fault_o pulses one cycle, pair_pending_o=0, no out_valid_o.
REQ-037 rst_i asserted in PAIR_WAIT with flush_i=1 and a valid halfword -> all REQ-028 values next cycle, pair_fault_o=0.

Source files
------------

// File: rtl/instr_pair_ctrl.sv
// Thumb halfword pairing: joins 32-bit prefixes with their second half
// and presents whole instructions to decode through an output register.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   instr_valid_i          fetch offers instruction_i this cycle
//   instruction_i[15:0]    fetched halfword
//   instr_ready_o          halfword is taken this cycle
//   stall_i                decode cannot take a new instruction
//   flush_i                redirect, drop all held state
//   out_valid_o            instruction presented to decode
//   first_hw_o[15:0]       first (or only) halfword
//   second_hw_o[15:0]      second halfword, zero for 16-bit
//   is_32bit_o             presented instruction is 32-bit
//   pair_pending_o         prefix held, second half outstanding
//   pair_fault_o           one-cycle pulse on pairing timeout
//
// Optional: define INSTR_PAIR_TIMEOUT_EN to abort a pair after
// TIMEOUT_CYCLES idle cycles waiting for the second half.
module instr_pair_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  input  logic [15:0] instruction_i,
  output logic        instr_ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  output logic [15:0] first_hw_o,
  output logic [15:0] second_hw_o,
  output logic        is_32bit_o,
  output logic        pair_pending_o,
  output logic        pair_fault_o
);

  typedef enum logic {
    IDLE,
    PAIR_WAIT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] prefix_q;
  logic        out_valid_q;
  logic [15:0] first_q;
  logic [15:0] second_q;
  logic        is32_q;

  logic        accept;
  logic        is_prefix;
  logic        pfx_take;
  logic        load_16;
  logic        load_32;
  logic        timeout_hit;

  assign instr_ready_o = !out_valid_q || !stall_i;
  assign accept = instr_valid_i && instr_ready_o && !flush_i;

  // 11101, 11110, 11111 open a 32-bit encoding
  assign is_prefix = (instruction_i[15:13] == 3'b111)
                  && (instruction_i[12:11] != 2'b00);

  assign pfx_take = accept && (state_q == IDLE) && is_prefix;
  assign load_16  = accept && (state_q == IDLE) && !is_prefix;
  assign load_32  = accept && (state_q == PAIR_WAIT);

`ifdef INSTR_PAIR_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       fault_q;

  assign timeout_hit = (state_q == PAIR_WAIT) && !accept
                    && !flush_i
                    && (cnt_q + 8'd1 == 8'(TIMEOUT_CYCLES));

  // counter sits at zero in IDLE so it is clear on PAIR_WAIT entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= timeout_hit;
      if (flush_i || state_q == IDLE || accept)
        cnt_q <= 8'd0;
      else
        cnt_q <= cnt_q + 8'd1;
    end
  end

  assign pair_fault_o = fault_q;
`else
  logic [7:0] unused_timeout;

  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign pair_fault_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      flush_i:     state_d = IDLE;
      pfx_take:    state_d = PAIR_WAIT;
      load_32:     state_d = IDLE;
      timeout_hit: state_d = IDLE;
      default:     ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      prefix_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (flush_i || timeout_hit)
        prefix_q <= 16'h0000;
      else if (pfx_take)
        prefix_q <= instruction_i;
    end
  end

  // a load in the drain cycle keeps out_valid high for 1/cycle flow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      first_q     <= 16'h0000;
      second_q    <= 16'h0000;
      is32_q      <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (load_16) begin
      out_valid_q <= 1'b1;
      first_q     <= instruction_i;
      second_q    <= 16'h0000;
      is32_q      <= 1'b0;
    end else if (load_32) begin
      out_valid_q <= 1'b1;
      first_q     <= prefix_q;
      second_q    <= instruction_i;
      is32_q      <= 1'b1;
    end else if (out_valid_q && !stall_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign first_hw_o     = first_q;
  assign second_hw_o    = second_q;
  assign is_32bit_o     = is32_q;
  assign pair_pending_o = (state_q == PAIR_WAIT);

endmodule

// File: tb/tb_instr_pair_ctrl.sv
// Bench for instr_pair_ctrl: directed vector table, pairing corner
// sequences and random traffic against a halfword-queue model.
module tb_instr_pair_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ov;
  logic [15:0] fhw;
  logic [15:0] shw;
  logic        is32;
  logic        pend;
  logic        fault;

  instr_pair_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_valid_i  (valid),
    .instruction_i  (instr),
    .instr_ready_o  (ready),
    .stall_i        (stall),
    .flush_i        (flush),
    .out_valid_o    (ov),
    .first_hw_o     (fhw),
    .second_hw_o    (shw),
    .is_32bit_o     (is32),
    .pair_pending_o (pend),
    .pair_fault_o   (fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // model: pending prefix kept as a 0/1-entry queue
  logic [15:0] pfx_q[$];
  bit          m_ov;
  logic [15:0] m_f;
  logic [15:0] m_s;
  bit          m_32;
  bit          m_fault;
  int          m_idle;
  bit          rdy_seen;

  function automatic bit starts32(input logic [15:0] h);
    return h[15:11] == 5'b11101 || h[15:11] == 5'b11110
        || h[15:11] == 5'b11111;
  endfunction

  task automatic model_reset();
    pfx_q.delete();
    m_ov = 0; m_f = 0; m_s = 0; m_32 = 0;
    m_fault = 0; m_idle = 0;
  endtask

  task automatic cyc(input bit v, input logic [15:0] hw,
                     input bit st, input bit fl, input bit rs);
    bit rdy;
    bit acc;
    bit drained;
    @(negedge clk);
    valid = v; instr = hw; stall = st;
    flush = fl; rst = rs;
    #1;
    rdy = !m_ov || !st;
    rdy_seen = ready;
    if (!rs) chk("ready", ready, rdy);
    acc = v && rdy && !fl;
    drained = !(m_ov && st);
    if (rs) begin
      model_reset();
    end else if (fl) begin
      pfx_q.delete();
      m_ov = 0; m_fault = 0; m_idle = 0;
    end else begin
      m_fault = 0;
      if (acc && pfx_q.size() != 0) begin
        m_f = pfx_q.pop_front();
        m_s = hw; m_32 = 1; m_ov = 1;
      end else if (acc && starts32(hw)) begin
        pfx_q.push_back(hw);
        m_idle = 0;
        if (drained) m_ov = 0;
      end else if (acc) begin
        m_f = hw; m_s = 0; m_32 = 0; m_ov = 1;
      end else begin
        if (drained) m_ov = 0;
`ifdef INSTR_PAIR_TIMEOUT_EN
        if (pfx_q.size() != 0) begin
          m_idle++;
          if (m_idle == T) begin
            pfx_q.delete();
            m_fault = 1;
            m_idle = 0;
          end
        end
`endif
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", ov, m_ov);
    chk("first_hw", fhw, m_f);
    chk("second_hw", shw, m_s);
    chk("is_32bit", is32, m_32);
    chk("pair_pending", pend, pfx_q.size() != 0);
    chk("pair_fault", fault, m_fault);
  endtask

  typedef struct {
    bit          rs;
    bit          v;
    logic [15:0] hw;
    bit          st;
    bit          fl;
    bit          e_rdy;
    bit          e_ov;
    logic [15:0] e_f;
    logic [15:0] e_s;
    bit          e_32;
    bit          e_pend;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1,0,16'h0000,0,0, 1,0,16'h0000,16'h0000,0,0};
    tbl[1]  = '{0,1,16'h2005,0,0, 1,1,16'h2005,16'h0000,0,0};
    tbl[2]  = '{0,0,16'h0000,0,0, 1,0,16'h2005,16'h0000,0,0};
    tbl[3]  = '{0,1,16'hF000,0,0, 1,0,16'h2005,16'h0000,0,1};
    tbl[4]  = '{0,1,16'hF800,0,0, 1,1,16'hF000,16'hF800,1,0};
    tbl[5]  = '{0,1,16'h4400,1,0, 0,1,16'hF000,16'hF800,1,0};
    tbl[6]  = '{0,1,16'h4400,1,0, 0,1,16'hF000,16'hF800,1,0};
    tbl[7]  = '{0,1,16'h4400,1,0, 0,1,16'hF000,16'hF800,1,0};
    tbl[8]  = '{0,1,16'h4400,0,0, 1,1,16'h4400,16'h0000,0,0};
    tbl[9]  = '{0,1,16'hF000,0,0, 1,0,16'h4400,16'h0000,0,1};
    tbl[10] = '{0,1,16'h2005,0,1, 1,0,16'h4400,16'h0000,0,0};
    tbl[11] = '{0,1,16'h2105,0,0, 1,1,16'h2105,16'h0000,0,0};
    tbl[12] = '{0,1,16'hF000,0,0, 1,0,16'h2105,16'h0000,0,1};
    tbl[13] = '{1,1,16'hF800,0,1, 1,0,16'h0000,16'h0000,0,0};
    tbl[14] = '{0,1,16'hE800,0,0, 1,0,16'h0000,16'h0000,0,1};
    tbl[15] = '{0,1,16'hF000,0,0, 1,1,16'hE800,16'hF000,1,0};
    tbl[16] = '{0,1,16'hE7FF,0,0, 1,1,16'hE7FF,16'h0000,0,0};
    tbl[17] = '{0,0,16'h0000,0,0, 1,0,16'hE7FF,16'h0000,0,0};

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", ov, 0);
    chk("rst_pend", pend, 0);
    chk("rst_fault", fault, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].hw, tbl[i].st,
          tbl[i].fl, tbl[i].rs);
      if (!tbl[i].rs)
        chk($sformatf("t%0d_rdy", i), rdy_seen, tbl[i].e_rdy);
      chk($sformatf("t%0d_ov", i), ov, tbl[i].e_ov);
      chk($sformatf("t%0d_f", i), fhw, tbl[i].e_f);
      chk($sformatf("t%0d_s", i), shw, tbl[i].e_s);
      chk($sformatf("t%0d_32", i), is32, tbl[i].e_32);
      chk($sformatf("t%0d_pend", i), pend, tbl[i].e_pend);
    end

    // prefix left waiting with no traffic
    cyc(1, 16'hF000, 0, 0, 0);
`ifdef INSTR_PAIR_TIMEOUT_EN
    for (int k = 1; k < T; k++) begin
      cyc(0, 16'h0000, 0, 0, 0);
      chk("to_pend_hold", pend, 1);
      chk("to_no_fault", fault, 0);
    end
    cyc(0, 16'h0000, 0, 0, 0);
    chk("to_fault_pulse", fault, 1);
    chk("to_pend_clear", pend, 0);
    chk("to_no_out", ov, 0);
    cyc(0, 16'h0000, 0, 0, 0);
    chk("to_fault_end", fault, 0);
`else
    for (int k = 0; k < 20; k++) begin
      cyc(0, 16'h0000, 0, 0, 0);
      chk("wait_pend_hold", pend, 1);
      chk("wait_no_fault", fault, 0);
    end
    cyc(1, 16'hF123, 0, 0, 0);
    chk("wait_pair_f", fhw, 16'hF000);
    chk("wait_pair_s", shw, 16'hF123);
`endif

    // prefix arriving while output is stalled must wait
    cyc(1, 16'h1111, 0, 0, 0);
    cyc(1, 16'hF000, 1, 0, 0);
    chk("stall_no_take", pend, 0);
    chk("stall_hold", fhw, 16'h1111);

    for (int k = 0; k < 600; k++) begin
      logic [15:0] hw;
      hw = 16'($urandom);
      if ($urandom_range(0, 9) < 4)
        hw[15:11] = 5'($urandom_range(29, 31));
      cyc($urandom_range(0, 9) < 7, hw,
          $urandom_range(0, 9) < 3,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
